// File: rtl/mod_counter_pkg.sv
// Shared types and constants for the modulo up/down counter.
package mod_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

endpackage

// File: rtl/mod_counter_next.sv
// Combinational next-value and wrap calculator for a modulo-MODULUS count,
// shared by the up and down directions.
module mod_counter_next
    import mod_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up_dn,
    output logic [WIDTH-1:0] next,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // Explicit compare against MAX even for MODULUS == 2**WIDTH, so the wrap
    // flag is produced the same way for every modulus.
    always_comb begin
        next = q;
        wrap = 1'b0;
        if (up_dn == DIR_UP) begin
            if (q == MAX) begin
                next = '0;
                wrap = 1'b1;
            end else begin
                next = q + ONE;
            end
        end else begin
            if (q == '0) begin
                next = MAX;
                wrap = 1'b1;
            end else begin
                next = q - ONE;
            end
        end
    end

endmodule

// File: rtl/mod_counter.sv
// Falling-edge modulo-MODULUS up/down counter with load, enable, one-shot mode
// and terminal-count pulse. Define MOD_COUNTER_GRAY_EN to add the q_gray output.
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             one_shot,
    input  logic             start,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy,
    output logic             done
`ifdef MOD_COUNTER_GRAY_EN
    ,
    output logic [WIDTH-1:0] q_gray
`endif
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    generate
        if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
            $error("mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_d;
    logic             tc_d;
    logic [WIDTH-1:0] cnt_next;
    logic             cnt_wrap;
    logic [WIDTH-1:0] load_clamped;

    mod_counter_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .q     (q),
        .up_dn (up_dn),
        .next  (cnt_next),
        .wrap  (cnt_wrap)
    );

    assign load_clamped = (load_val > MAX) ? MAX : load_val;

    // Priority: load > count > hold. start only matters outside RUN, and a
    // load on the same edge still lets start move the FSM into RUN.
    always_comb begin
        state_d = state_q;
        q_d     = q;
        tc_d    = 1'b0;
        if (load) begin
            q_d = load_clamped;
            if (start && state_q != ST_RUN) state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (en) begin
                        q_d  = cnt_next;
                        tc_d = cnt_wrap;
                        if (cnt_wrap && one_shot) state_d = ST_DONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(negedge clock or posedge clear) begin
        if (clear) begin
            state_q <= ST_IDLE;
            q       <= '0;
            tc      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            q       <= q_d;
            tc      <= tc_d;
            busy    <= (state_d == ST_RUN);
            done    <= (state_d == ST_DONE);
        end
    end

`ifdef MOD_COUNTER_GRAY_EN
    always_ff @(negedge clock or posedge clear) begin
        if (clear) q_gray <= '0;
        else       q_gray <= q_d ^ (q_d >> 1);
    end
`endif

endmodule

// File: doc/mod_counter.md
Name: mod_counter

Overview:
- Parametrised synchronous successor to the T-flip-flop ripple counter.
- Provides a WIDTH-bit modulo-MODULUS up/down counter with parallel load, count enable, free-run or one-shot mode, and a terminal-count pulse.
- Used as a stimulus and timing source in the example designs. Counts on the falling edge of clock, as the ripple counter family does.

Parameters:
- WIDTH, 4, counter width in bits.
- MODULUS, 16, count range 0..MODULUS-1. Legal range is 2 ≤ MODULUS ≤ 2**WIDTH; any other value is an elaboration error.

Ports:
- clock  in  1  clock; all state changes on its falling edge.
- clear  in  1  reset; asynchronous, active-high.
- en  in  1  count enable, effective in RUN only.
- up_dn  in  1  1 = count up, 0 = count down.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value to load.
- one_shot  in  1  1 = stop after one wrap, 0 = free-run.
- start  in  1  begin or restart counting.
- q  out  WIDTH  count value.
- tc  out  1  registered terminal-count pulse.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.

Behaviour:
- clear=1, asynchronously: q=0, tc=0, state=IDLE, busy=0, done=0.
  - Held while clear=1; falling edges are ignored.
  - Mid-operation clear aborts immediately.
- Priority at each falling edge: clear > load > count > hold.
- States:
  - IDLE: q holds.
  - RUN: counts when en=1.
  - DONE: q holds.
- Transitions:
  - IDLE or DONE with start=1 → RUN.
  - start is ignored in RUN.
  - RUN with one_shot=1 and a wrap on this edge → DONE.
  - RUN with one_shot=0 stays in RUN indefinitely.
- load=1 (any state): q ← min(load_val, MODULUS-1). State is unchanged, no count occurs that edge, tc=0.
- load=1 together with start=1 in IDLE/DONE: the load takes effect and the state becomes RUN. Counting begins on the next edge.
- Count (RUN, en=1, load=0):
  - Up: q==MODULUS-1 → 0 (wrap); otherwise q+1.
  - Down: q==0 → MODULUS-1 (wrap); otherwise q-1.
- en=0 in RUN: hold, tc=0.
- up_dn may change every cycle and is sampled at each edge. Wrap detection uses the up_dn value sampled on that edge.
- tc rises on the wrap edge and falls on the next edge: exactly one clock period high, aligned with q showing the wrapped value.
- One-shot wrap: q takes the wrapped value and holds in DONE.
- busy = (state==RUN); done = (state==DONE). Both are registered.
- Latency: count, load, tc and state changes are all visible one falling edge after the sampled inputs. No combinational input→output paths.
- With MODULUS=2**WIDTH the wrap is the natural binary overflow; the same compare logic must still be used.

Optional Feature:
- Macro: MOD_COUNTER_GRAY_EN.
- Defined: adds output q_gray [WIDTH], registered, equal to q ^ (q>>1) in the same cycle as q. Reset value is 0.
- Not defined: the port and its logic do not exist.

Decomposition:
- Package mod_counter_pkg holds:
  - the state enum (ST_IDLE, ST_RUN, ST_DONE);
  - direction constants (DIR_DOWN=0, DIR_UP=1).
- Optional sub-module mod_counter_next: combinational next-value/wrap calculator (q, up_dn, MODULUS → next, wrap). Reused by the up and down paths.
- State register and outputs stay in mod_counter.

Test Plan (WIDTH=4, MODULUS=10):
1. Free-run up: clear 1→0 at t=34, start pulse, en=1, up_dn=1, one_shot=0 → q runs 0..9,0,1. tc is high one period with q=0 after 9; busy=1.
2. Down with load: load_val=3, load=1 for one edge, then up_dn=0 → q runs 3,2,1,0,9,8. tc is high only while q=9 follows 0.
3. One-shot: one_shot=1, start, up from 0 → after q=9 the next edge gives q=0, tc=1, done=1, busy=0. Five more edges with en=1 leave q=0, tc=0; a start pulse → RUN, counting resumes 1,2.
4. Clamp and simultaneity: load_val=12 with load=1 and start=1 in IDLE → q=9, state RUN. Next edge up gives q=0, tc=1.
5. Async clear mid-count: assert clear between edges at q=6 → q=0, tc=0, busy=0 without a clock edge. After release, edges with en=1 keep q=0 until start.
6. MOD_COUNTER_GRAY_EN defined, free-run up → q_gray sequence 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101 for q=0..9. q_gray=0 after wrap.
